cache_fill_fsm: RTL and testbench

Miss-handling controller that sits between the CPU's instruction/data caches and the multi-cycle main memory. On a cache miss it fetches the full 16-byte block (8 words) containing the missing address by streaming word requests to memory. It steers each returning word into the cache data array and writes the tag once the final word lands. It is the block that feeds the CPU's fetch and load paths when the single-cycle memories are replaced by caches.

---
 rtl/cache_fill_fsm_pkg.sv | 17 +
 rtl/cache_fill_fsm_fill_counter.sv | 26 ++
 rtl/cache_fill_fsm.sv | 108 ++++++++++
 tb/tb_cache_fill_fsm.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/cache_fill_fsm_pkg.sv
// Shared definitions for the cache miss fill controller.
//   state_t      : FSM state encoding (IDLE=0, FILL=1), one flop wide
//   BLOCK_BYTES  : bytes per cache block
//   WORD_BYTES   : bytes per memory word
//   OFFSET_BITS  : byte-offset bits inside a block (cleared to form block_base)
package cache_fill_fsm_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_t;

  localparam int BLOCK_BYTES = 16;
  localparam int WORD_BYTES  = 2;
  localparam int OFFSET_BITS = 4;

endpackage

// File: rtl/cache_fill_fsm_fill_counter.sv
// Small up-counter used for the request and receive word counters.
//   clk, rst_n : clock, asynchronous active-low reset (count -> 0)
//   clear      : synchronous clear, wins over enable
//   enable     : increment by one this cycle
//   count      : current count
module fill_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         enable,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/cache_fill_fsm.sv
// Cache miss fill controller. On an accepted miss it streams one read
// request per cycle for every word of the 16-byte block, steers each
// returning word into the data array and writes the tag on the last beat.
//   clk, rst_n         : clock, asynchronous active-low reset
//   miss_detected      : cache reports a miss (accepted only in IDLE)
//   miss_address       : byte address of the missing access
//   memory_data_valid  : memory returns one word this cycle
//   fsm_busy           : fill in progress, CPU stalls
//   memory_read        : read request this cycle
//   memory_address     : byte address of the current request
//   write_data_array   : write the returning word into the data array
//   word_offset        : word index of that write within the block
//   write_tag_array    : write tag / set valid for the filled block
module cache_fill_fsm
  import cache_fill_fsm_pkg::*;
#(
  parameter int WORDS_PER_BLOCK = 8,
  parameter int ADDR_W          = 16
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               miss_detected,
  input  logic [ADDR_W-1:0]                  miss_address,
  input  logic                               memory_data_valid,
  output logic                               fsm_busy,
  output logic                               memory_read,
  output logic [ADDR_W-1:0]                  memory_address,
  output logic                               write_data_array,
  output logic [$clog2(WORDS_PER_BLOCK)-1:0] word_offset,
  output logic                               write_tag_array
);

  localparam int IDX_W      = $clog2(WORDS_PER_BLOCK);
  localparam int CNT_W      = IDX_W + 1;
  localparam int BYTE_SEL_W = $clog2(WORD_BYTES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS_PER_BLOCK - 1);

  state_t                       state;
  state_t                       state_next;
  logic                         accept;
  logic [ADDR_W-OFFSET_BITS-1:0] block_base;
  logic [CNT_W-1:0]             req_cnt;
  logic [CNT_W-1:0]             rx_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Block base is pure data: only meaningful while FILL, so it carries no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      block_base <= miss_address[ADDR_W-1:OFFSET_BITS];
    end
  end

  always_comb begin
    state_next       = state;
    accept           = 1'b0;
    write_data_array = 1'b0;
    write_tag_array  = 1'b0;
    case (state)
      IDLE: begin
        if (miss_detected) begin
          accept     = 1'b1;
          state_next = FILL;
        end
      end
      FILL: begin
        if (memory_data_valid) begin
          write_data_array = 1'b1;
          if (rx_cnt[IDX_W-1:0] == LAST_IDX) begin
            write_tag_array = 1'b1;
            state_next      = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Request side runs purely from flops: the MSB of req_cnt marks "all issued".
  assign fsm_busy       = (state == FILL);
  assign memory_read    = fsm_busy && !req_cnt[IDX_W];
  assign memory_address = memory_read ?
                          {block_base, req_cnt[IDX_W-1:0], {BYTE_SEL_W{1'b0}}} : '0;
  assign word_offset    = write_data_array ? rx_cnt[IDX_W-1:0] : '0;

  fill_counter #(.W(CNT_W)) u_req_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (accept),
    .enable (memory_read),
    .count  (req_cnt)
  );

  fill_counter #(.W(CNT_W)) u_rx_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (accept),
    .enable (write_data_array),
    .count  (rx_cnt)
  );

endmodule

// File: tb/tb_cache_fill_fsm.sv
module tb_cache_fill_fsm;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        miss_detected = 1'b0;
  logic [15:0] miss_address = '0;
  logic        memory_data_valid = 1'b0;
  logic        fsm_busy;
  logic        memory_read;
  logic [15:0] memory_address;
  logic        write_data_array;
  logic [2:0]  word_offset;
  logic        write_tag_array;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] addr_q[$];
  int          off_q[$];

  always #5 clk = ~clk;

  cache_fill_fsm #(.WORDS_PER_BLOCK(8), .ADDR_W(16)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .miss_detected     (miss_detected),
    .miss_address      (miss_address),
    .memory_data_valid (memory_data_valid),
    .fsm_busy          (fsm_busy),
    .memory_read       (memory_read),
    .memory_address    (memory_address),
    .write_data_array  (write_data_array),
    .word_offset       (word_offset),
    .write_tag_array   (write_tag_array)
  );

  // Idle cycles: nothing may be written or requested, whatever valid does.
  task automatic idle_check(input string name, input int n, input logic [31:0] vmask);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      miss_detected     = 1'b0;
      memory_data_valid = vmask[i];
      #1;
      n_checks++;
      if (fsm_busy !== 1'b0) begin
        n_fail++; $display("FAIL %s busy cyc%0d got %b want 0", name, i, fsm_busy);
      end
      n_checks++;
      if (memory_read !== 1'b0) begin
        n_fail++; $display("FAIL %s read cyc%0d got %b want 0", name, i, memory_read);
      end
      n_checks++;
      if (write_data_array !== 1'b0) begin
        n_fail++; $display("FAIL %s wr cyc%0d got %b want 0", name, i, write_data_array);
      end
      n_checks++;
      if (write_tag_array !== 1'b0) begin
        n_fail++; $display("FAIL %s tag cyc%0d got %b want 0", name, i, write_tag_array);
      end
    end
    memory_data_valid = 1'b0;
  endtask

  // Cycle c=0 is the cycle whose closing edge accepts the miss. vmask bit c
  // drives memory_data_valid in cycle c. Returns after checking the last-beat
  // cycle, or after the beat that brings the total to abort_beats (if > 0).
  task automatic run_fill(input string name, input logic [15:0] addr,
                          input logic [31:0] vmask, input bit hold,
                          input logic [15:0] alt, input int abort_beats);
    int beats = 0;
    int last  = -1;
    int cnt   = 0;
    bit exp_read, exp_wr, exp_tag, exp_busy;
    logic [15:0] ea;
    int eo;
    for (int i = 1; i < 32; i++) begin
      if (vmask[i]) begin
        cnt++;
        if (cnt == 8) last = i;
      end
    end
    if (last < 0) begin
      n_checks++; n_fail++;
      $display("FAIL %s bad_pattern got %0d beats want 8", name, cnt);
      return;
    end
    addr_q.delete();
    off_q.delete();
    for (int c = 0; c <= last; c++) begin
      @(negedge clk);
      miss_detected     = (c == 0) || hold;
      miss_address      = (hold && c >= 4) ? alt : addr;
      memory_data_valid = vmask[c];
      if (c == 0) begin
        for (int i = 0; i < 8; i++) begin
          addr_q.push_back({addr[15:4], 4'h0} + 16'(2 * i));
          off_q.push_back(i);
        end
      end
      #1;
      exp_busy = (c >= 1);
      exp_read = (c >= 1) && (c <= 8);
      exp_wr   = (c >= 1) && vmask[c];
      exp_tag  = exp_wr && (beats == 7);
      n_checks++;
      if (fsm_busy !== exp_busy) begin
        n_fail++; $display("FAIL %s busy cyc%0d got %b want %b", name, c, fsm_busy, exp_busy);
      end
      n_checks++;
      if (memory_read !== exp_read) begin
        n_fail++; $display("FAIL %s read cyc%0d got %b want %b", name, c, memory_read, exp_read);
      end
      if (memory_read === 1'b1) begin
        n_checks++;
        if (addr_q.size() == 0) begin
          n_fail++; $display("FAIL %s extra_req cyc%0d got 0x%04h want none", name, c, memory_address);
        end else begin
          ea = addr_q.pop_front();
          if (memory_address !== ea) begin
            n_fail++; $display("FAIL %s addr cyc%0d got 0x%04h want 0x%04h", name, c, memory_address, ea);
          end
        end
      end
      n_checks++;
      if (write_data_array !== exp_wr) begin
        n_fail++; $display("FAIL %s wr cyc%0d got %b want %b", name, c, write_data_array, exp_wr);
      end
      if (write_data_array === 1'b1) begin
        n_checks++;
        if (off_q.size() == 0) begin
          n_fail++; $display("FAIL %s extra_wr cyc%0d got %0d want none", name, c, word_offset);
        end else begin
          eo = off_q.pop_front();
          if (int'(word_offset) != eo) begin
            n_fail++; $display("FAIL %s offset cyc%0d got %0d want %0d", name, c, word_offset, eo);
          end
        end
      end
      n_checks++;
      if (write_tag_array !== exp_tag) begin
        n_fail++; $display("FAIL %s tag cyc%0d got %b want %b", name, c, write_tag_array, exp_tag);
      end
      if (exp_wr) beats++;
      if (abort_beats > 0 && beats == abort_beats) return;
    end
    n_checks++;
    if (addr_q.size() != 0) begin
      n_fail++; $display("FAIL %s req_count got %0d missing want 0", name, addr_q.size());
    end
    n_checks++;
    if (off_q.size() != 0) begin
      n_fail++; $display("FAIL %s beat_count got %0d missing want 0", name, off_q.size());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    n_checks++;
    if ({fsm_busy, memory_read, write_data_array, write_tag_array} !== 4'b0000 ||
        memory_address !== 16'h0 || word_offset !== 3'd0) begin
      n_fail++; $display("FAIL reset_outputs got %b/%h/%0d want 0000/0000/0",
        {fsm_busy, memory_read, write_data_array, write_tag_array}, memory_address, word_offset);
    end
    rst_n = 1'b1;
    idle_check("post_reset", 2, 32'h0);
  endtask

  task automatic test_basic_fill();
    run_fill("basic", 16'h1236, 32'h0000_1FE0, 1'b0, 16'h0, 0);
    idle_check("basic_after", 2, 32'h0);
  endtask

  task automatic test_top_of_memory();
    run_fill("top_mem", 16'hFFFA, 32'h0000_1FE0, 1'b0, 16'h0, 0);
    idle_check("top_mem_after", 1, 32'h0);
  endtask

  task automatic test_irregular_valid();
    run_fill("gaps", 16'h2468, 32'h0001_B9A0, 1'b0, 16'h0, 0);
    idle_check("gaps_after", 1, 32'h0);
  endtask

  task automatic test_back_to_back();
    // Miss held high across the whole fill (including the last-beat cycle)
    // with a new address mid-fill; the second fill opens one cycle after busy drops.
    run_fill("held_first", 16'h3456, 32'h0000_1FE0, 1'b1, 16'h7770, 0);
    run_fill("held_second", 16'h7770, 32'h0000_1FE0, 1'b0, 16'h0, 0);
    idle_check("held_after", 1, 32'h0);
  endtask

  task automatic test_reset_mid_fill();
    run_fill("abort", 16'h4008, 32'h0000_1FE0, 1'b0, 16'h0, 3);
    @(negedge clk);
    rst_n             = 1'b0;
    miss_detected     = 1'b0;
    memory_data_valid = 1'b1;
    #1;
    n_checks++;
    if ({fsm_busy, memory_read, write_data_array, write_tag_array} !== 4'b0000) begin
      n_fail++; $display("FAIL abort_outputs got %b want 0000",
        {fsm_busy, memory_read, write_data_array, write_tag_array});
    end
    @(negedge clk);
    memory_data_valid = 1'b0;
    rst_n = 1'b1;
    idle_check("abort_idle", 2, 32'h0);
    run_fill("after_abort", 16'h5678, 32'h0000_1FE0, 1'b0, 16'h0, 0);
    idle_check("after_abort_idle", 1, 32'h0);
  endtask

  task automatic test_idle_valid();
    idle_check("idle_valid", 6, 32'h0000_002D);
  endtask

  initial begin
    test_reset();
    test_basic_fill();
    test_top_of_memory();
    test_irregular_valid();
    test_back_to_back();
    test_reset_mid_fill();
    test_idle_valid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
